// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS controller.
// Moore FSM that sequences fetch/decode/execute/memory/writeback over one
// shared memory and one ALU. It drives the datapath mux selects, the register
// file, PC and memory strobes. It also raises an illegal-instruction trap and
// keeps a count of retired instructions.
//
// Optional build macro: MIPS_CTRL_JUMP_EN
//   defined   : J (opcode 000010) is executed through a dedicated JUMP state
//   undefined : J traps to ILLEGAL; the JUMP state is not built and pc_src
//               never takes the jump-target select
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  FETCH   | read instruction at PC, load IR, PC <= PC + 4 (waits on memory)
//  DECODE  | classify opcode/funct, precompute branch target into ALUOut
//  MEMADR  | effective address A + sign-ext imm
//  MEMRD   | load data read from ALUOut address (waits on memory)
//  MEMWB   | write loaded data to rt, retire
//  MEMWR   | store B to ALUOut address (waits on memory), retire
//  RTEX    | R-type ALU operation A op B
//  RTWB    | write ALU result to rd, retire
//  BRANCH  | BEQ compare A - B, PC <= ALUOut when zero, retire
//  ADDIEX  | A + sign-ext imm
//  IWB     | write ALU result to rt, retire
//  JUMP    | PC <= jump target, retire (MIPS_CTRL_JUMP_EN only)
//  ILLEGAL | trap, all strobes off, left only through reset

module mips_multicycle_ctrl #(
    parameter int ALU_OP_W  = 4,
    parameter int RET_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 mem_ready,
    input  logic                 zero,
    output logic                 pc_write,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_src,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 instr_done,
    output logic                 illegal_op,
    output logic [RET_CNT_W-1:0] retired_cnt,
    output logic [3:0]           state_out
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTEX    = 4'd6;
    localparam logic [3:0] S_RTWB    = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_IWB     = 4'd10;
`ifdef MIPS_CTRL_JUMP_EN
    localparam logic [3:0] S_JUMP    = 4'd11;
`endif
    localparam logic [3:0] S_ILLEGAL = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_CTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
`ifdef MIPS_CTRL_JUMP_EN
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
`endif

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       is_store;
    logic       funct_ok;
    logic [3:0] rt_alu;
    logic [3:0] alu_code;

    // R-type funct legality and the ALU operation it selects
    always_comb begin
        funct_ok = 1'b1;
        rt_alu   = ALU_ADD;
        case (funct)
            FN_ADD:  rt_alu = ALU_ADD;
            FN_SUB:  rt_alu = ALU_SUB;
            FN_AND:  rt_alu = ALU_AND;
            FN_OR:   rt_alu = ALU_OR;
            FN_SLT:  rt_alu = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // Next-state selection; opcode/funct are only looked at in DECODE
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)
                    state_nxt = S_MEMADR;
                else if (opcode == OP_RTYPE && funct_ok)
                    state_nxt = S_RTEX;
                else if (opcode == OP_BEQ)
                    state_nxt = S_BRANCH;
                else if (opcode == OP_ADDI)
                    state_nxt = S_ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
                else if (opcode == OP_J)
                    state_nxt = S_JUMP;
`endif
                else
                    state_nxt = S_ILLEGAL;
            end
            S_MEMADR:  state_nxt = is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:   state_nxt = S_FETCH;
            S_MEMWR:   if (mem_ready) state_nxt = S_FETCH;
            S_RTEX:    state_nxt = S_RTWB;
            S_RTWB:    state_nxt = S_FETCH;
            S_BRANCH:  state_nxt = S_FETCH;
            S_ADDIEX:  state_nxt = S_IWB;
            S_IWB:     state_nxt = S_FETCH;
`ifdef MIPS_CTRL_JUMP_EN
            S_JUMP:    state_nxt = S_FETCH;
`endif
            S_ILLEGAL: state_nxt = S_ILLEGAL;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    // Remember load vs store at DECODE so MEMADR does not depend on the IR
    always_ff @(posedge clk) begin
        if (reset)
            is_store <= 1'b0;
        else if (state == S_DECODE)
            is_store <= (opcode == OP_SW);
    end

    // Per-state datapath controls; everything is held off while in reset
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        alu_code   = ALU_AND;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_code  = ALU_ADD;
                    pc_src    = PCSRC_ALU;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMMSH;
                    alu_code  = ALU_ADD;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_code  = ALU_ADD;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                S_RTEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_REG;
                    alu_code  = rt_alu;
                end
                S_RTWB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_REG;
                    alu_code   = ALU_SUB;
                    pc_src     = PCSRC_ALUOUT;
                    pc_write   = zero;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_code  = ALU_ADD;
                end
                S_IWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef MIPS_CTRL_JUMP_EN
                S_JUMP: begin
                    pc_src     = PCSRC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                S_ILLEGAL: illegal_op = 1'b1;
                default: ;
            endcase
        end
    end

    assign alu_op    = ALU_OP_W'(alu_code);
    assign state_out = state;

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk) begin
        if (reset)
            retired_cnt <= '0;
        else if (instr_done)
            retired_cnt <= retired_cnt + 1'b1;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// The model expands each instruction into its phase sequence and derives the
// expected controls of every phase; a compare process checks every cycle.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;
    localparam int AW = 5;
    localparam int CW = 3;
    localparam int VW = 15 + AW;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
    localparam int P_MEMWR = 5, P_RTEX = 6, P_RTWB = 7, P_BRANCH = 8, P_ADDIEX = 9;
    localparam int P_IWB = 10, P_JUMP = 11, P_ILLEGAL = 12;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic mem_ready = 1'b0;
    logic zero = 1'b0;
    logic pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [AW-1:0] alu_op;
    logic [CW-1:0] retired_cnt;
    logic [3:0] state_out;

    mips_multicycle_ctrl #(.ALU_OP_W(AW), .RET_CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .zero(zero), .pc_write(pc_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
        .retired_cnt(retired_cnt), .state_out(state_out)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] act_vec;
    assign act_vec = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                      reg_write, alu_src_a, alu_src_b, pc_src, alu_op, instr_done, illegal_op};

    int n_pass = 0;
    int n_total = 0;
    logic chk_en = 1'b0;
    int exp_state = 0;
    logic [VW-1:0] exp_vec = '0;
    logic [VW-1:0] exp_mask = '0;
    logic [CW-1:0] exp_cnt = '0;
    int mcnt = 0;
    logic prev_done = 1'b0;
    logic prev_rst = 1'b0;
    int cur_phase = P_FETCH;
    int lat_cnt = 0;
    int last_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        else
            n_pass++;
    endtask

    function automatic logic [VW-1:0] pack(input logic pcw, input logic io, input logic mrd,
            input logic mwr, input logic irw, input logic rdst, input logic m2r, input logic rw,
            input logic asa, input logic [1:0] asb, input logic [1:0] psrc, input logic [3:0] op,
            input logic done, input logic ill);
        return {pcw, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, psrc, AW'(op), done, ill};
    endfunction

    // Controls each phase must show, straight from the per-state rules
    function automatic logic [VW-1:0] outs_for(input int ph, input logic [5:0] fn,
            input logic mr, input logic z, input logic rst);
        logic pcw, io, mrd, mwr, irw, rdst, m2r, rw, asa, done, ill;
        logic [1:0] asb, psrc;
        logic [3:0] op;
        {pcw, io, mrd, mwr, irw, rdst, m2r, rw, asa, done, ill} = '0;
        asb = 2'b00; psrc = 2'b00; op = 4'b0000;
        case (ph)
            P_FETCH:   begin mrd = 1; asb = 2'b01; op = 4'b0010; irw = mr; pcw = mr; end
            P_DECODE:  begin asb = 2'b11; op = 4'b0010; end
            P_MEMADR:  begin asa = 1; asb = 2'b10; op = 4'b0010; end
            P_MEMRD:   begin io = 1; mrd = 1; end
            P_MEMWB:   begin rw = 1; m2r = 1; done = 1; end
            P_MEMWR:   begin io = 1; mwr = 1; done = mr; end
            P_RTEX: begin
                asa = 1;
                case (fn)
                    FN_SUB:  op = 4'b0110;
                    FN_AND:  op = 4'b0000;
                    FN_OR:   op = 4'b0001;
                    FN_SLT:  op = 4'b0111;
                    default: op = 4'b0010;
                endcase
            end
            P_RTWB:    begin rdst = 1; rw = 1; done = 1; end
            P_BRANCH:  begin asa = 1; op = 4'b0110; psrc = 2'b01; pcw = z; done = 1; end
            P_ADDIEX:  begin asa = 1; asb = 2'b10; op = 4'b0010; end
            P_IWB:     begin rw = 1; done = 1; end
            P_JUMP:    begin psrc = 2'b10; pcw = 1; done = 1; end
            P_ILLEGAL: ill = 1;
            default: ;
        endcase
        if (rst) {pcw, mrd, mwr, irw, rw, done, ill} = '0;
        return pack(pcw, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, psrc, op, done, ill);
    endfunction

    // Instruction class: 0 LW, 1 SW, 2 R-type, 3 BEQ, 4 ADDI, 5 J, 6 illegal
    function automatic int kind(input logic [5:0] opc, input logic [5:0] fn);
        if (opc == OP_LW) return 0;
        if (opc == OP_SW) return 1;
        if (opc == OP_R && (fn == FN_ADD || fn == FN_SUB || fn == FN_AND ||
                            fn == FN_OR || fn == FN_SLT)) return 2;
        if (opc == OP_BEQ) return 3;
        if (opc == OP_ADDI) return 4;
`ifdef MIPS_CTRL_JUMP_EN
        if (opc == OP_J) return 5;
`endif
        return 6;
    endfunction

    task automatic step(input int ph, input logic mr, input logic z, input logic [5:0] opc,
                        input logic [5:0] fn, input logic rst);
        logic [VW-1:0] v;
        @(posedge clk); #1;
        if (prev_rst) mcnt = 0;
        else if (prev_done) mcnt = (mcnt + 1) % (1 << CW);
        reset = rst; mem_ready = mr; zero = z; opcode = opc; funct = fn;
        v = outs_for(ph, fn, mr, z, rst);
        exp_vec = v;
        exp_mask = rst ? pack(1, 0, 1, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 1, 1) : '1;
        exp_state = ph;
        exp_cnt = CW'(mcnt);
        prev_done = v[1];
        prev_rst = rst;
        cur_phase = ph;
        chk_en = 1'b1;
    endtask

    task automatic do_reset();
        step(cur_phase, 1'b1, 1'b0, opcode, funct, 1'b1);
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    // One instruction: fw fetch waits, mw memory waits, hold cycles if it traps
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input int hold);
        int k;
        logic nz;
        k = kind(opc, fn);
        nz = ~z;
        for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, nz, ~opc, ~fn, 1'b0);
        step(P_FETCH, 1'b1, nz, ~opc, ~fn, 1'b0);
        step(P_DECODE, 1'b1, nz, opc, fn, 1'b0);
        case (k)
            0: begin
                step(P_MEMADR, 1'b1, nz, ~opc, ~fn, 1'b0);
                for (int i = 0; i < mw; i++) step(P_MEMRD, 1'b0, nz, ~opc, ~fn, 1'b0);
                step(P_MEMRD, 1'b1, nz, ~opc, ~fn, 1'b0);
                step(P_MEMWB, 1'b1, nz, ~opc, ~fn, 1'b0);
            end
            1: begin
                step(P_MEMADR, 1'b1, nz, ~opc, ~fn, 1'b0);
                for (int i = 0; i < mw; i++) step(P_MEMWR, 1'b0, nz, ~opc, ~fn, 1'b0);
                step(P_MEMWR, 1'b1, nz, ~opc, ~fn, 1'b0);
            end
            2: begin
                step(P_RTEX, 1'b1, nz, ~opc, fn, 1'b0);
                step(P_RTWB, 1'b1, nz, ~opc, ~fn, 1'b0);
            end
            3: step(P_BRANCH, 1'b1, z, ~opc, ~fn, 1'b0);
            4: begin
                step(P_ADDIEX, 1'b1, nz, ~opc, ~fn, 1'b0);
                step(P_IWB, 1'b1, nz, ~opc, ~fn, 1'b0);
            end
            5: step(P_JUMP, 1'b1, nz, ~opc, ~fn, 1'b0);
            default: for (int i = 0; i < hold; i++)
                step(P_ILLEGAL, logic'(i[0]), nz, ~opc, ~fn, 1'b0);
        endcase
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state_out), 32'(exp_state));
            check("controls", 32'(act_vec & exp_mask), 32'(exp_vec & exp_mask));
            check("retired_cnt", 32'(retired_cnt), 32'(exp_cnt));
        end
    end

    // Cycles from the end of the previous instruction up to this retire
    always @(negedge clk) begin
        if (reset) lat_cnt = 0;
        else begin
            lat_cnt++;
            if (instr_done === 1'b1) begin
                last_lat = lat_cnt;
                lat_cnt = 0;
            end
        end
    end

    initial begin
        do_reset();
        run_instr(OP_R, FN_ADD, 1'b0, 0, 0, 0);
        mid(); check("add_latency", 32'(last_lat), 32'd4);
        step(P_FETCH, 1'b0, 1'b0, 6'h3f, 6'h3f, 1'b0);
        mid(); check("cnt_after_add", 32'(retired_cnt), 32'd1);

        run_instr(OP_ADDI, 6'h15, 1'b0, 0, 0, 0);
        run_instr(OP_LW, 6'h07, 1'b0, 0, 2, 0);
        mid(); check("lw_latency", 32'(last_lat), 32'd7);
        run_instr(OP_SW, 6'h2a, 1'b1, 1, 1, 0);
        mid(); check("sw_latency", 32'(last_lat), 32'd6);
        run_instr(OP_BEQ, 6'h00, 1'b1, 0, 0, 0);
        mid(); check("beq_latency", 32'(last_lat), 32'd3);
        run_instr(OP_BEQ, 6'h00, 1'b0, 0, 0, 0);
        step(P_FETCH, 1'b0, 1'b0, 6'h3f, 6'h3f, 1'b0);
        mid(); check("cnt_after_beq", 32'(retired_cnt), 32'd6);

        run_instr(OP_R, FN_SUB, 1'b0, 0, 0, 0);
        run_instr(OP_R, FN_AND, 1'b1, 0, 0, 0);
        run_instr(OP_R, FN_OR, 1'b0, 0, 0, 0);
        run_instr(OP_R, FN_SLT, 1'b0, 0, 0, 0);

        run_instr(OP_J, 6'h11, 1'b0, 0, 0, 3);
`ifdef MIPS_CTRL_JUMP_EN
        mid(); check("j_latency", 32'(last_lat), 32'd3);
`else
        mid(); check("j_traps", 32'(illegal_op), 32'd1);
        do_reset();
`endif

        run_instr(OP_R, 6'b000001, 1'b0, 0, 0, 4);
        mid(); check("bad_funct_trap", 32'(illegal_op), 32'd1);
        do_reset();

        run_instr(6'b111111, 6'h00, 1'b0, 0, 0, 10);
        mid(); check("illegal_held", 32'(illegal_op), 32'd1);
        do_reset();
        mid(); check("illegal_in_reset", 32'(illegal_op), 32'd0);
        step(P_FETCH, 1'b0, 1'b0, 6'h3f, 6'h3f, 1'b0);
        mid(); check("state_after_trap_reset", 32'(state_out), 32'd0);

        do_reset();
        for (int i = 0; i < 9; i++) run_instr(OP_ADDI, 6'(i), 1'b0, 0, 0, 0);
        step(P_FETCH, 1'b0, 1'b0, 6'h3f, 6'h3f, 1'b0);
        mid(); check("cnt_wrap", 32'(retired_cnt), 32'd1);

        step(P_FETCH, 1'b1, 1'b0, 6'h00, 6'h00, 1'b0);
        step(P_DECODE, 1'b1, 1'b0, OP_SW, 6'h00, 1'b0);
        step(P_MEMADR, 1'b1, 1'b0, OP_LW, 6'h00, 1'b0);
        step(P_MEMWR, 1'b0, 1'b0, OP_LW, 6'h00, 1'b0);
        do_reset();
        mid();
        check("no_mem_write_in_reset", 32'(mem_write), 32'd0);
        check("no_done_in_reset", 32'(instr_done), 32'd0);
        step(P_FETCH, 1'b0, 1'b0, 6'h3f, 6'h3f, 1'b0);
        mid();
        check("state_after_memwr_reset", 32'(state_out), 32'd0);
        check("cnt_after_memwr_reset", 32'(retired_cnt), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
